// File: rtl/sdram_rr_arbiter_if.sv
// rtl/sdram_rr_arbiter_if.sv - burst port between the arbiter (master) and sdram_core (slave)
interface sdram_rr_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9,
    parameter int DQ_W   = 16
);
    logic              wr_burst_req;
    logic [LEN_W-1:0]  wr_burst_len;
    logic [ADDR_W-1:0] wr_burst_addr;
    logic [DQ_W-1:0]   wr_burst_data;
    logic              wr_burst_data_req;
    logic              wr_burst_finish;
    logic              rd_burst_req;
    logic [LEN_W-1:0]  rd_burst_len;
    logic [ADDR_W-1:0] rd_burst_addr;
    logic [DQ_W-1:0]   rd_burst_data;
    logic              rd_burst_data_valid;
    logic              rd_burst_finish;

    modport master (
        output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  wr_burst_data_req, wr_burst_finish,
        input  rd_burst_data, rd_burst_data_valid, rd_burst_finish
    );

    modport slave (
        input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output wr_burst_data_req, wr_burst_finish,
        output rd_burst_data, rd_burst_data_valid, rd_burst_finish
    );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// rtl/sdram_rr_arbiter.sv - round-robin arbiter sharing one sdram_core burst port among NUM_REQ masters
module sdram_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 9,
    parameter int DQ_W    = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        m_req,
    input  logic [NUM_REQ-1:0]        m_we,
    input  logic [NUM_REQ*LEN_W-1:0]  m_len,
    input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
    input  logic [NUM_REQ*DQ_W-1:0]   m_wr_data,
    output logic [NUM_REQ-1:0]        m_wr_data_req,
    output logic [DQ_W-1:0]           m_rd_data,
    output logic [NUM_REQ-1:0]        m_rd_valid,
    output logic [NUM_REQ-1:0]        m_finish,
    output logic [NUM_REQ-1:0]        m_err,
    output logic                      busy,
    sdram_rr_arbiter_if.master        core
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_DONE} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, grant, win, ptr_nxt;
    logic               found;
    logic               we_q, armed, err_q;
    logic [LEN_W-1:0]   len_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt;
    logic               tmo, req_on, accept, core_done;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && m_req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    assign ptr_nxt = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    // The first S_REQ cycle (armed=0) presents len/addr before the request rises.
    assign tmo       = (cnt == CNT_W'(TIMEOUT));
    assign req_on    = (state == S_REQ) && armed && !tmo;
    assign accept    = (state == S_REQ) && armed &&
                       (we_q ? core.wr_burst_data_req : core.rd_burst_data_valid);
    assign core_done = we_q ? core.wr_burst_finish : core.rd_burst_finish;
    assign busy      = (state == S_REQ) || (state == S_BUSY);

    assign core.wr_burst_req  = req_on && we_q && !core.wr_burst_data_req;
    assign core.rd_burst_req  = req_on && !we_q && !core.rd_burst_data_valid;
    assign core.wr_burst_len  = len_q;
    assign core.rd_burst_len  = len_q;
    assign core.wr_burst_addr = addr_q;
    assign core.rd_burst_addr = addr_q;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (found) state_n = S_REQ;
            S_REQ: begin
                if (len_q == '0 || tmo) state_n = S_DONE;
                else if (accept)        state_n = S_BUSY;
            end
            S_BUSY: if (core_done || tmo) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ptr    <= '0;
            grant  <= '0;
            we_q   <= 1'b0;
            len_q  <= '0;
            addr_q <= '0;
            cnt    <= '0;
            armed  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    armed <= 1'b0;
                    err_q <= 1'b0;
                    cnt   <= '0;
                    if (found) begin
                        grant  <= win;
                        we_q   <= m_we[win];
                        len_q  <= m_len[int'(win)*LEN_W +: LEN_W];
                        addr_q <= m_addr[int'(win)*ADDR_W +: ADDR_W];
                        ptr    <= ptr_nxt;
                    end
                end
                S_REQ: begin
                    armed <= 1'b1;
                    err_q <= tmo && (len_q != '0);
                    if (!tmo) cnt <= cnt + 1'b1;
                end
                S_BUSY: begin
                    err_q <= tmo && !core_done;
                    if (!tmo) cnt <= cnt + 1'b1;
                end
                default: armed <= 1'b0;
            endcase
        end
    end

    always_comb begin
        m_wr_data_req      = '0;
        m_rd_valid         = '0;
        m_finish           = '0;
        m_err              = '0;
        m_rd_data          = '0;
        core.wr_burst_data = '0;
        if (busy) begin
            core.wr_burst_data   = m_wr_data[int'(grant)*DQ_W +: DQ_W];
            m_wr_data_req[grant] = core.wr_burst_data_req && we_q;
            m_rd_valid[grant]    = core.rd_burst_data_valid && !we_q;
            m_rd_data            = core.rd_burst_data;
        end
        if (state == S_DONE) begin
            m_finish[grant] = 1'b1;
            m_err[grant]    = err_q;
        end
    end
endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// tb/tb_sdram_rr_arbiter.sv - scoreboard bench for sdram_rr_arbiter with a behavioural sdram_core
module tb_sdram_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 24;
    localparam int LEN_W   = 9;
    localparam int DQ_W    = 16;
    localparam int TMO     = 40;

    typedef struct {
        int m; bit err; int wr_n; int rd_n; int reqs; int req_cyc; int len; int addr; bit we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NUM_REQ-1:0]        m_req, m_we, m_wr_data_req, m_rd_valid, m_finish, m_err;
    logic [NUM_REQ*LEN_W-1:0]  m_len;
    logic [NUM_REQ*ADDR_W-1:0] m_addr;
    logic [NUM_REQ*DQ_W-1:0]   m_wr_data;
    logic [DQ_W-1:0]           m_rd_data;
    logic                      busy;

    sdram_rr_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DQ_W(DQ_W)) core_if ();

    sdram_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DQ_W(DQ_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_len(m_len), .m_addr(m_addr),
        .m_wr_data(m_wr_data), .m_wr_data_req(m_wr_data_req), .m_rd_data(m_rd_data),
        .m_rd_valid(m_rd_valid), .m_finish(m_finish), .m_err(m_err), .busy(busy), .core(core_if)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int vectors = 0, miscompares = 0, fin_count = 0, clear_all_at = -1;
    bit [NUM_REQ-1:0] auto_drop = '1;
    bit core_mute = 1'b0;
    int fin_delay = 0;
    int seen_len, seen_addr;
    bit seen_we;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_master(input int i, input bit we, input int len, input int addr);
        m_we[i]                 = we;
        m_len[i*LEN_W +: LEN_W] = len[LEN_W-1:0];
        m_addr[i*ADDR_W +: ADDR_W] = addr[ADDR_W-1:0];
    endtask

    task automatic push(input int m, input bit err, input int wr_n, input int rd_n, input int reqs,
                        input int req_cyc, input int len, input int addr, input bit we);
        exp_t e;
        e.m = m; e.err = err; e.wr_n = wr_n; e.rd_n = rd_n; e.reqs = reqs;
        e.req_cyc = req_cyc; e.len = len; e.addr = addr; e.we = we;
        sb.push_back(e);
    endtask

    task automatic wait_fin(input int target, input int budget);
        int n = 0;
        while (fin_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (fin_count < target) check("wait_finish_budget", fin_count, target);
    endtask

    // Behavioural core: request seen, 2-cycle accept latency, len beats, then finish.
    initial begin
        core_if.wr_burst_data_req = 1'b0; core_if.wr_burst_finish = 1'b0;
        core_if.rd_burst_data = '0; core_if.rd_burst_data_valid = 1'b0; core_if.rd_burst_finish = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!core_mute && rst_n && (core_if.wr_burst_req || core_if.rd_burst_req)) begin
                seen_we   = core_if.wr_burst_req;
                seen_len  = seen_we ? int'(core_if.wr_burst_len) : int'(core_if.rd_burst_len);
                seen_addr = seen_we ? int'(core_if.wr_burst_addr) : int'(core_if.rd_burst_addr);
                repeat (2) begin @(posedge clk); #1; end
                for (int k = 0; k < seen_len; k++) begin
                    if (seen_we) core_if.wr_burst_data_req = 1'b1;
                    else begin
                        core_if.rd_burst_data_valid = 1'b1;
                        core_if.rd_burst_data = DQ_W'($urandom);
                    end
                    @(posedge clk); #1;
                end
                core_if.wr_burst_data_req = 1'b0;
                core_if.rd_burst_data_valid = 1'b0;
                repeat (fin_delay) begin @(posedge clk); #1; end
                if (seen_we) core_if.wr_burst_finish = 1'b1; else core_if.rd_burst_finish = 1'b1;
                @(posedge clk); #1;
                core_if.wr_burst_finish = 1'b0;
                core_if.rd_burst_finish = 1'b0;
            end
        end
    end

    // Monitor: per-burst activity is accumulated and compared when m_finish appears.
    initial begin
        int wr_cnt = 0, rd_cnt = 0, reqs = 0, req_cyc = 0;
        bit prev_req = 1'b0, cur_req;
        forever begin
            @(negedge clk);
            cur_req = core_if.wr_burst_req || core_if.rd_burst_req;
            if (!rst_n) begin
                wr_cnt = 0; rd_cnt = 0; reqs = 0; req_cyc = 0; prev_req = 1'b0;
            end else begin
                if (cur_req && !prev_req) reqs++;
                if (cur_req) req_cyc++;
                prev_req = cur_req;
                if (sb.size() > 0) begin
                    logic [NUM_REQ-1:0] oh;
                    oh = '0;
                    oh[sb[0].m] = 1'b1;
                    if (m_wr_data_req != '0 || m_rd_valid != '0)
                        check("steer_other_bits", (m_wr_data_req | m_rd_valid) & ~oh, 0);
                    if (m_wr_data_req[sb[0].m]) begin
                        wr_cnt++;
                        check("wr_burst_data", core_if.wr_burst_data, 16'hA000 + sb[0].m);
                    end
                    if (m_rd_valid[sb[0].m]) begin
                        rd_cnt++;
                        check("m_rd_data", m_rd_data, core_if.rd_burst_data);
                    end
                end
                if (m_finish != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_finish", m_finish, 0);
                    end else begin
                        exp_t e;
                        longint oh_e;
                        e = sb.pop_front();
                        oh_e = longint'(1) << e.m;
                        check("m_finish_grant", m_finish, oh_e);
                        check("m_err", m_err, e.err ? oh_e : 0);
                        check("wr_beats", wr_cnt, e.wr_n);
                        check("rd_beats", rd_cnt, e.rd_n);
                        check("core_req_count", reqs, e.reqs);
                        check("core_req_cycles", req_cyc, e.req_cyc);
                        if (e.reqs == 1 && !e.err) begin
                            check("core_len", seen_len, e.len);
                            check("core_addr", seen_addr, e.addr);
                            check("core_dir", seen_we, e.we);
                        end
                    end
                    fin_count++;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (m_finish[i] && auto_drop[i]) m_req[i] = 1'b0;
                    if (fin_count == clear_all_at) m_req = '0;
                    wr_cnt = 0; rd_cnt = 0; reqs = 0; req_cyc = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0; m_req = '0; m_we = '0; m_len = '0; m_addr = '0;
        m_wr_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_wr_req", core_if.wr_burst_req, 0);
        check("rst_rd_req", core_if.rd_burst_req, 0);
        check("rst_finish", m_finish, 0);
        check("rst_len_addr", {core_if.wr_burst_len, core_if.wr_burst_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_master(0, 1, 8, 24'h000100);
        push(0, 0, 8, 0, 1, 2, 8, 24'h000100, 1);
        m_req[0] = 1'b1;
        wait_fin(1, 200);

        set_master(2, 0, 16, 24'h123456);
        push(2, 0, 0, 16, 1, 2, 16, 24'h123456, 0);
        m_req[2] = 1'b1;
        wait_fin(2, 200);

        // Pointer sits at 3: wrap-around must pick 0 before 2.
        set_master(0, 1, 4, 24'h000200);
        set_master(2, 0, 3, 24'h000300);
        push(0, 0, 4, 0, 1, 2, 4, 24'h000200, 1);
        push(2, 0, 0, 3, 1, 2, 3, 24'h000300, 0);
        m_req = 4'b0101;
        wait_fin(4, 300);

        set_master(1, 1, 0, 24'h000400);
        push(1, 0, 0, 0, 0, 0, 0, 24'h000400, 1);
        @(negedge clk);
        m_req[1] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
        end while (!m_finish[1] && fin_count < 5 && lat < 20);
        check("zero_len_latency", lat, 2);
        wait_fin(5, 50);

        // Contention from pointer 2, all masters held: 2,3,0,1 twice.
        for (int i = 0; i < NUM_REQ; i++) set_master(i, (i % 2) == 0, 2, i * 4096);
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < NUM_REQ; j++) begin
                int m;
                m = (2 + j) % NUM_REQ;
                push(m, 0, (m % 2 == 0) ? 2 : 0, (m % 2 == 0) ? 0 : 2, 1, 2, 2, m * 4096, m % 2 == 0);
            end
        auto_drop = '0;
        clear_all_at = 13;
        m_req = 4'b1111;
        wait_fin(13, 600);
        auto_drop = '1;
        clear_all_at = -1;
        @(negedge clk);

        set_master(3, 1, 4, 24'h0ABCDE);
        core_mute = 1'b1;
        push(3, 1, 0, 0, 1, TMO - 1, 4, 24'h0ABCDE, 1);
        m_req[3] = 1'b1;
        wait_fin(14, 200);
        @(negedge clk);
        core_mute = 1'b0;

        // Reset during S_BUSY; the late core finish then lands in S_IDLE.
        set_master(1, 0, 4, 24'h000500);
        fin_delay = 50;
        m_req[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        m_req = '0;
        @(posedge clk); #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rd_req", core_if.rd_burst_req, 0);
        check("rst_mid_outputs", {m_finish, m_err, m_rd_valid, m_wr_data_req}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        fin_delay = 0;

        for (int i = 0; i < NUM_REQ; i++) begin
            set_master(i, 1, 1, 24'h000600 + i);
            push(i, 0, 1, 0, 1, 2, 1, 24'h000600 + i, 1);
        end
        m_req = 4'b1111;
        wait_fin(18, 400);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdram_rr_arbiter.md
Name: sdram_rr_arbiter

Overview:
- Round-robin arbiter that shares one sdram_core burst interface between NUM_REQ independent masters (e.g. camera write DMA, video read DMA).
- Each master issues one read or write burst at a time.
- The arbiter latches the winner's length and address, drives the core's wr/rd burst request, steers the data handshakes to the winner, and returns a per-master finish pulse.
- It sits directly between the masters' FIFOs and sdram_core.

Parameters:
- NUM_REQ, 4, number of masters (2..8)
- ADDR_W, 24, burst address width (bank+row+col)
- LEN_W, 9, burst length width
- DQ_W, 16, data width
- TIMEOUT, 4095, cycles allowed from core request to core finish before abort

Ports:
- clk  in  1  system clock, same as sdram_core
- rst_n  in  1  synchronous active-low reset
- m_req  in  NUM_REQ  per-master burst request, level, held until m_finish
- m_we  in  NUM_REQ  per-master direction, 1=write 0=read, stable while m_req
- m_len  in  NUM_REQ*LEN_W  per-master burst length, packed, master i at [i*LEN_W +: LEN_W]
- m_addr  in  NUM_REQ*ADDR_W  per-master base address, packed
- m_wr_data  in  NUM_REQ*DQ_W  per-master write data, packed
- m_wr_data_req  out  NUM_REQ  write data request to the granted master, 1 clock ahead
- m_rd_data  out  DQ_W  read data, broadcast to all masters
- m_rd_valid  out  NUM_REQ  read data valid, granted master only
- m_finish  out  NUM_REQ  1-cycle completion pulse
- m_err  out  NUM_REQ  1-cycle timeout pulse, coincident with m_finish
- busy  out  1  a grant is active
- wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data  out  1/LEN_W/ADDR_W/DQ_W  to core write port
- wr_burst_data_req, wr_burst_finish  in  1/1  from core
- rd_burst_req, rd_burst_len, rd_burst_addr  out  1/LEN_W/ADDR_W  to core read port
- rd_burst_data  in  DQ_W, rd_burst_data_valid in 1, rd_burst_finish in 1  from core

Behaviour:
- Reset: all outputs 0, state S_IDLE, round-robin pointer = 0, latched len/addr = 0.
- States: S_IDLE, S_REQ, S_BUSY, S_DONE.
- S_IDLE:
  - If any m_req is set, choose the first set bit searching from pointer upward with wrap-around.
  - Latch grant index, we, len and addr.
  - Go to S_REQ next cycle; pointer = grant+1 mod NUM_REQ.
  - If the latched len == 0: skip the core, go to S_DONE directly; m_finish pulses, no core request is issued.
- S_REQ:
  - wr_burst_req (we=1) or rd_burst_req (we=0) is held at 1; the other request stays 0.
  - wr/rd_burst_len and wr/rd_burst_addr come from latched registers and are stable at least 1 cycle before the request rises.
  - Acceptance is the first wr_burst_data_req (write) or rd_burst_data_valid (read) from the core. On acceptance the request drops the same cycle (combinationally gated) and the state moves to S_BUSY.
  - Core refresh may delay acceptance without limit up to TIMEOUT.
- S_BUSY:
  - Wait for wr_burst_finish or rd_burst_finish matching direction, then go to S_DONE.
- S_DONE:
  - m_finish[grant] pulses for exactly 1 cycle.
  - busy=0 next cycle; return to S_IDLE.
  - Minimum 1 idle cycle between grants.
- Steering, combinational from latched grant while in S_REQ/S_BUSY:
  - wr_burst_data = m_wr_data[grant].
  - m_wr_data_req[grant] = wr_burst_data_req; all other bits 0.
  - m_rd_valid[grant] = rd_burst_data_valid; m_rd_data = rd_burst_data.
- busy = 1 in S_REQ and S_BUSY.
- Timeout:
  - A counter clears on entering S_REQ and increments in S_REQ/S_BUSY.
  - When it reaches TIMEOUT: drop the core request, pulse m_finish and m_err for the grant, go to S_DONE.
- A master that drops m_req mid-grant is ignored; the burst completes normally.
- A core finish arriving in S_IDLE is ignored.
- Simultaneous requests are resolved purely by pointer order. No master is granted twice while another is continuously requesting.
- Reset mid-burst: state returns to S_IDLE and core requests drop the next edge. Core recovery is outside this block.

Test Plan:
- Single write: m_req[0]=1, we=1, len=8, addr=0x000100 → wr_burst_req rises 1 cycle after grant and drops on the first wr_burst_data_req. m_wr_data_req[0] shows 8 pulses. m_finish[0] pulses once after wr_burst_finish.
- Single read: m_req[2]=1, we=0, len=16 → m_rd_valid[2] shows 16 cycles carrying rd_burst_data. Other m_rd_valid bits stay 0. m_finish[2] pulses once.
- Contention: m_req=4'b1111 held continuously → grant order 0,1,2,3,0,…; each master gets exactly one burst per round.
- Wrap: pointer=3, m_req=4'b0101 → grant 0 first, then 2.
- Zero length: m_req[1]=1, len=0 → no core request. m_finish[1] pulses 2 cycles after request.
- Timeout and reset: core model never answers with TIMEOUT=15 → request dropped at cycle 15, m_err and m_finish pulse together. Assert rst_n=0 during S_BUSY → all outputs 0 on the next edge, pointer=0.
